// File: rtl/mtl_pkg.sv
// Shared types and default geometry for the MTL display path.
package mtl_pkg;

  localparam int H_ACTIVE_DEF   = 800;
  localparam int IMG_WORDS_DEF  = 384000;
  localparam int ADDR_W_DEF     = 24;
  localparam int SLIDE_STEP_DEF = 16;

  typedef enum logic [1:0] {
    WAIT_IMG = 2'd0,
    SHOW     = 2'd1,
    ARM      = 2'd2,
    SLIDE    = 2'd3
  } state_t;

  typedef enum logic {
    DIR_E = 1'b0,
    DIR_W = 1'b1
  } dir_t;

endpackage

// File: rtl/slide_index_wrap.sv
// Next/previous slide index, wrapping modulo the image count. Purely combinational.
module slide_index_wrap (
  input  logic [7:0] cur,
  input  logic [7:0] tot,
  output logic [7:0] nxt,
  output logic [7:0] prv
);

  assign nxt = (cur == tot - 8'd1) ? 8'd0 : cur + 8'd1;
  assign prv = (cur == 8'd0) ? tot - 8'd1 : cur - 8'd1;

endmodule

// File: rtl/slide_transition_scheduler.sv
// Slide index tracking and frame-locked wipe transitions between the two MMU pixel read ports.
// All port programming happens on the iNew_Frame cycle; load_new pulses in the cycle after.
module slide_transition_scheduler
  import mtl_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int IMG_WORDS  = IMG_WORDS_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int SLIDE_STEP = SLIDE_STEP_DEF
) (
  input  logic              iCLK,
  input  logic              iRST_n,
  input  logic [7:0]        iImg_Tot,
  input  logic              iImage_loaded,
  input  logic              iGest_E,
  input  logic              iGest_W,
  input  logic              iNew_Frame,
  output logic              o_load_new_1,
  output logic              o_load_new_2,
  output logic [ADDR_W-1:0] o_base_address_1,
  output logic [ADDR_W-1:0] o_base_address_2,
  output logic [ADDR_W-1:0] o_max_address_1,
  output logic [ADDR_W-1:0] o_max_address_2,
  output logic [9:0]        o_split_col,
  output logic [7:0]        o_cur_index,
  output logic              o_busy,
  output logic [1:0]        o_state
);

  localparam logic [9:0]        SPLIT_FULL = 10'(H_ACTIVE);
  localparam logic [ADDR_W-1:0] MAX_OFS    = ADDR_W'(IMG_WORDS - 1);

  // Addresses wrap silently at ADDR_W bits; ADDR_W is assumed <= 32.
  function automatic logic [ADDR_W-1:0] base_of(input logic [7:0] k);
    logic [31:0] prod;
    prod = 32'(k) * 32'(IMG_WORDS);
    return prod[ADDR_W-1:0];
  endfunction

  state_t            state, state_n;
  dir_t              dir, dir_n;
  logic [7:0]        cur, cur_n, tgt, tgt_n;
  logic [9:0]        off, off_n, split, split_n;
  logic [ADDR_W-1:0] b1, b1_n, b2, b2_n, m1, m1_n, m2, m2_n;
  logic [ADDR_W-1:0] base_cur, base_tgt;
  logic              load, load_n;
  logic [7:0]        nxt, prv;
  logic [10:0]       off_sum;
  logic [9:0]        off_step;
  logic [9:0]        wipe_off;

  slide_index_wrap u_wrap (
    .cur (cur),
    .tot (iImg_Tot),
    .nxt (nxt),
    .prv (prv)
  );

  assign off_sum  = {1'b0, off} + 11'(SLIDE_STEP);
  assign off_step = (off_sum >= 11'(H_ACTIVE)) ? SPLIT_FULL : off_sum[9:0];

  always_comb begin
    state_n  = state;
    dir_n    = dir;
    cur_n    = cur;
    tgt_n    = tgt;
    off_n    = off;
    split_n  = split;
    b1_n     = b1;
    b2_n     = b2;
    m1_n     = m1;
    m2_n     = m2;
    load_n   = 1'b0;
    wipe_off = 10'd0;

    if (!iImage_loaded) begin
      state_n = WAIT_IMG;
      cur_n   = 8'd0;
      split_n = SPLIT_FULL;
    end else if (state == WAIT_IMG) begin
      if (iImg_Tot != 8'd0) state_n = SHOW;
    end else if (iNew_Frame && (cur >= iImg_Tot)) begin
      // Image count shrank under us: fall back to slide 0 and drop any wipe.
      state_n = SHOW;
      cur_n   = 8'd0;
      b1_n    = '0;
      b2_n    = '0;
      split_n = SPLIT_FULL;
      load_n  = 1'b1;
    end else begin
      case (state)
        SHOW: begin
          if (iNew_Frame) begin
            b1_n    = base_cur;
            b2_n    = base_cur;
            split_n = SPLIT_FULL;
            load_n  = 1'b1;
          end
          if ((iImg_Tot > 8'd1) && (iGest_E || iGest_W)) begin
            dir_n   = iGest_E ? DIR_E : DIR_W;
            tgt_n   = iGest_E ? nxt : prv;
            state_n = ARM;
          end
        end
        ARM, SLIDE: begin
          if (iNew_Frame) begin
            load_n = 1'b1;
            if ((state == SLIDE) && (off == SPLIT_FULL)) begin
              cur_n   = tgt;
              b1_n    = base_tgt;
              b2_n    = base_tgt;
              split_n = SPLIT_FULL;
              state_n = SHOW;
            end else begin
              wipe_off = (state == ARM) ? 10'd0 : off_step;
              off_n    = wipe_off;
              state_n  = SLIDE;
              if (dir == DIR_E) begin
                b1_n    = base_cur;
                b2_n    = base_tgt;
                split_n = SPLIT_FULL - wipe_off;
              end else begin
                b1_n    = base_tgt;
                b2_n    = base_cur;
                split_n = wipe_off;
              end
            end
          end
        end
        default: ;
      endcase
    end

    if (load_n) begin
      m1_n = b1_n + MAX_OFS;
      m2_n = b2_n + MAX_OFS;
    end
  end

  // base_cur/base_tgt track the index registers one-for-one, so they are valid
  // on any frame cycle, including one that immediately follows a gesture.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state    <= WAIT_IMG;
      dir      <= DIR_E;
      cur      <= 8'd0;
      tgt      <= 8'd0;
      off      <= 10'd0;
      split    <= SPLIT_FULL;
      b1       <= '0;
      b2       <= '0;
      m1       <= '0;
      m2       <= '0;
      load     <= 1'b0;
      base_cur <= '0;
      base_tgt <= '0;
    end else begin
      state    <= state_n;
      dir      <= dir_n;
      cur      <= cur_n;
      tgt      <= tgt_n;
      off      <= off_n;
      split    <= split_n;
      b1       <= b1_n;
      b2       <= b2_n;
      m1       <= m1_n;
      m2       <= m2_n;
      load     <= load_n;
      base_cur <= base_of(cur_n);
      base_tgt <= base_of(tgt_n);
    end
  end

  assign o_load_new_1     = load;
  assign o_load_new_2     = load;
  assign o_base_address_1 = b1;
  assign o_base_address_2 = b2;
  assign o_max_address_1  = m1;
  assign o_max_address_2  = m2;
  assign o_split_col      = split;
  assign o_cur_index      = cur;
  assign o_busy           = (state == ARM) || (state == SLIDE);
  assign o_state          = state;

endmodule

// File: tb/tb_slide_transition_scheduler.sv
// Bench for slide_transition_scheduler: directed scenarios plus randomized gestures/frames,
// checked against a frame-level model of the slideshow behaviour.
module tb_slide_transition_scheduler;

  localparam int H     = 800;
  localparam int IW    = 384000;
  localparam int AW    = 24;
  localparam int STEP  = 16;
  localparam int WIPE_FRAMES = (H + STEP - 1) / STEP + 1;
  localparam logic [AW-1:0] MAXO = AW'(IW - 1);

  logic          clk;
  logic          rst_n;
  logic [7:0]    tot;
  logic          loaded;
  logic          ge, gw, nf;
  logic          load1, load2;
  logic [AW-1:0] base1, base2, max1, max2;
  logic [9:0]    split;
  logic [7:0]    cur;
  logic          busy;
  logic [1:0]    state_dbg;

  slide_transition_scheduler dut (
    .iCLK             (clk),
    .iRST_n           (rst_n),
    .iImg_Tot         (tot),
    .iImage_loaded    (loaded),
    .iGest_E          (ge),
    .iGest_W          (gw),
    .iNew_Frame       (nf),
    .o_load_new_1     (load1),
    .o_load_new_2     (load2),
    .o_base_address_1 (base1),
    .o_base_address_2 (base2),
    .o_max_address_1  (max1),
    .o_max_address_2  (max2),
    .o_split_col      (split),
    .o_cur_index      (cur),
    .o_busy           (busy),
    .o_state          (state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [105:0] exp_q[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame-level reference model: mode 0 waiting, 1 showing, 2 armed, 3 wiping.
  int m_mode, m_cur, m_tgt, m_wf, m_split;
  bit m_dir_e, m_strobe;

  function automatic logic [AW-1:0] mbase(input int k);
    longint p;
    p = longint'(k) * longint'(IW);
    return p[AW-1:0];
  endfunction

  function automatic logic [105:0] mk(input int sp, input int p1, input int p2);
    logic [AW-1:0] a1, a2;
    a1 = mbase(p1);
    a2 = mbase(p2);
    return {10'(sp), a1, a1 + MAXO, a2, a2 + MAXO};
  endfunction

  task automatic push(input logic [105:0] r);
    exp_q.push_back(r);
    m_split = int'(r[105:96]);
  endtask

  task automatic push_wipe();
    int off;
    off = STEP * (m_wf - 1);
    if (off > H) off = H;
    if (m_dir_e) push(mk(H - off, m_cur, m_tgt));
    else         push(mk(off, m_tgt, m_cur));
  endtask

  task automatic model_step();
    int prev;
    prev = m_mode;
    m_strobe = 1'b0;
    if (!loaded) begin
      m_mode = 0; m_cur = 0; m_split = H;
      return;
    end
    if (m_mode == 0) begin
      if (tot != 0) m_mode = 1;
      return;
    end
    if (nf) begin
      m_strobe = 1'b1;
      if (m_cur >= int'(tot)) begin
        m_cur = 0; m_mode = 1;
        push(mk(H, 0, 0));
        return;
      end
      case (m_mode)
        1: push(mk(H, m_cur, m_cur));
        2: begin m_mode = 3; m_wf = 1; push_wipe(); end
        3: begin
          if (m_wf == WIPE_FRAMES) begin
            m_cur = m_tgt; m_mode = 1;
            push(mk(H, m_cur, m_cur));
          end else begin
            m_wf++;
            push_wipe();
          end
        end
        default: ;
      endcase
    end
    if (prev == 1 && tot > 1 && (ge || gw)) begin
      m_dir_e = ge;
      m_tgt   = ge ? (m_cur + 1) % int'(tot) : (m_cur + int'(tot) - 1) % int'(tot);
      m_mode  = 2;
    end
  endtask

  // Scoreboard
  task automatic scoreboard();
    check("load_new_1", load1, m_strobe);
    check("load_new_2", load2, m_strobe);
    if (m_strobe && exp_q.size() > 0)
      check("strobe_data", {split, base1, max1, base2, max2}, exp_q.pop_front());
    check("split", split, m_split);
    check("cur_index", cur, m_cur);
    check("busy", busy, m_mode >= 2);
  endtask

  // Driver tasks
  task automatic cyc(input bit f, input bit e, input bit w);
    nf = f; ge = e; gw = w;
    @(posedge clk);
    #1;
    model_step();
    scoreboard();
    nf = 1'b0; ge = 1'b0; gw = 1'b0;
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      cyc(1'b1, 1'b0, 1'b0);
      repeat (3) cyc(1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    rst_n = 1'b0; loaded = 1'b1; tot = 8'd3;
    nf = 1'b0; ge = 1'b0; gw = 1'b0;
    m_mode = 0; m_cur = 0; m_tgt = 0; m_wf = 0; m_split = H; m_dir_e = 1'b1; m_strobe = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_split", split, H);
    check("rst_load", {load1, load2}, 2'b00);
    check("rst_addr", {base1, base2, max1, max2}, 96'd0);
    check("rst_cur", cur, 0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;

    // Test 1: first frame after load strobes slide 0
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    check("t1_max1", max1, 383999);
    check("t1_split", split, 800);
    cyc(1'b0, 1'b0, 1'b0);

    // Test 2: east wipe 0 -> 1
    cyc(1'b0, 1'b1, 1'b0);
    frames(52);
    check("t2_cur", cur, 1);
    check("t2_base2", base2, 384000);
    check("t2_busy", busy, 1'b0);

    // Test 3: west wipes 1 -> 0 -> 2
    cyc(1'b0, 1'b0, 1'b1);
    frames(52);
    cyc(1'b0, 1'b0, 1'b1);
    frames(52);
    check("t3_cur", cur, 2);

    // Test 4: simultaneous E/W, extra gestures mid-wipe dropped
    cyc(1'b0, 1'b1, 1'b1);
    frames(5);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    frames(47);
    check("t4_cur", cur, 0);

    // Test 5: gesture on a frame cycle, then image set drops mid-wipe
    cyc(1'b1, 1'b1, 1'b0);
    frames(10);
    loaded = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    check("t5_state", state_dbg, 2'(mtl_pkg::WAIT_IMG));
    frames(2);
    loaded = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    frames(1);
    check("t5_base1", base1, 0);

    // Test 6: single image ignores gestures; count shrink resets index
    tot = 8'd1;
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    frames(2);
    check("t6_busy", busy, 1'b0);
    tot = 8'd3;
    cyc(1'b0, 1'b0, 1'b1);
    frames(52);
    check("t6_cur2", cur, 2);
    tot = 8'd1;
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    check("t6_cur0", cur, 0);

    // Randomized segments; image set toggled when the count changes
    repeat (4) begin
      loaded = 1'b0;
      cyc(1'b0, 1'b0, 1'b0);
      tot = 8'($urandom_range(2, 6));
      loaded = 1'b1;
      repeat (800) begin
        loaded = ($urandom_range(0, 299) != 0);
        cyc($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0);
      end
    end

    check("q_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
